// File: rtl/sns_disable_gen.sv
// ----------------------------------------------------------------------------
// sns_disable_gen
//
// Sensor-side producer of the 2-bit sensor-disable request for the drive-train
// pause handler. Each of the two raw bumper/obstacle inputs (bit0 = left,
// bit1 = right) is synchronised, debounced and turned into a single one-cycle
// request pulse. The handler's pause level is taken as the acknowledge: a
// channel will not fire again until pause has ended and its sensor has stayed
// released long enough to re-arm. A pulse that is never acknowledged sets the
// sticky ack_err flag.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sns_raw[1:0] raw asynchronous sensor inputs, active high
//   pause        pause level from the disable handler (acknowledge)
//   sns_disable  registered one-cycle request pulse per channel
//   busy         registered, channel not idle
//   ack_err      sticky: a pulse was not acknowledged within ACK_TIMEOUT
//   trip_cnt     {right,left} saturating 8-bit trip counters
//                (only present when TRIP_COUNT_EN is defined)
//
// Optional feature macro: TRIP_COUNT_EN
// ----------------------------------------------------------------------------
module sns_disable_gen #(
    parameter int DEBOUNCE    = 16,
    parameter int REARM       = 16,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sns_raw,
    input  logic        pause,
    output logic [1:0]  sns_disable,
    output logic [1:0]  busy,
    output logic        ack_err
`ifdef TRIP_COUNT_EN
    ,
    output logic [15:0] trip_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUAL,
        S_FIRE,
        S_WAIT_ACK,
        S_HOLD,
        S_REARM
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REARM_LAST = CNT_W'(REARM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0] timeout;
`ifdef TRIP_COUNT_EN
    logic [1:0] fire;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync_p0_q, sync_p1_q;
        logic             s;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             timeout_d;
        logic             dis_q, busy_q;

        // Stage p0/p1: two-flop synchroniser on the raw pin
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_p0_q <= 1'b0;
                sync_p1_q <= 1'b0;
            end else begin
                sync_p0_q <= sns_raw[g];
                sync_p1_q <= sync_p0_q;
            end
        end

        assign s = sync_p1_q;

        // Channel FSM: next state and counter
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            timeout_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = S_QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_QUAL: begin
                    if (!s) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_FIRE: begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                end
                S_WAIT_ACK: begin
                    if (pause) begin
                        state_d = S_HOLD;
                    end else if (cnt_q == ACK_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_REARM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state_d = S_REARM;
                        cnt_d   = '0;
                    end
                end
                S_REARM: begin
                    // Any sensor activity restarts the release window.
                    if (s) begin
                        cnt_d = '0;
                    end else if (cnt_q == REARM_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Stage p2: state register; outputs registered from the next state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                dis_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                dis_q   <= (state_d == S_FIRE);
                busy_q  <= (state_d != S_IDLE);
            end
        end

        assign sns_disable[g] = dis_q;
        assign busy[g]        = busy_q;
        assign timeout[g]     = timeout_d;
`ifdef TRIP_COUNT_EN
        assign fire[g]        = (state_d == S_FIRE);
`endif
    end

    logic ack_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_err_q <= 1'b0;
        end else if (|timeout) begin
            ack_err_q <= 1'b1;
        end
    end

    assign ack_err = ack_err_q;

`ifdef TRIP_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0][7:0] trip_q;

    // Counters advance on the same edge the pulse is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trip_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fire[i]) trip_q[i] <= sat_inc8(trip_q[i]);
            end
        end
    end

    assign trip_cnt = {trip_q[1], trip_q[0]};
`endif

endmodule

// File: tb/tb_sns_disable_gen.sv
module tb_sns_disable_gen;

    localparam int DEB = 4;
    localparam int RA  = 4;
    localparam int ACK = 4;
    localparam int BIG = 32'h3fff_ffff;

    logic       clk = 1'b1;
    logic       rst_n = 1'b1;
    logic [1:0] sns_raw = 2'b00;
    logic       pause = 1'b0;
    logic [1:0] sns_disable;
    logic [1:0] busy;
    logic       ack_err;
`ifdef TRIP_COUNT_EN
    logic [15:0] trip_cnt;
`endif

    sns_disable_gen #(
        .DEBOUNCE    (DEB),
        .REARM       (RA),
        .ACK_TIMEOUT (ACK),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sns_raw     (sns_raw),
        .pause       (pause),
        .sns_disable (sns_disable),
        .busy        (busy),
        .ack_err     (ack_err)
`ifdef TRIP_COUNT_EN
        ,
        .trip_cnt    (trip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int phase    = 0;
    int t0       = BIG;
    int t1       = BIG;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural model: each channel is described by what it is waiting for
    // (a long enough high run, an acknowledge, the end of pause, a long enough
    // low run) and how long it has been waiting.
    typedef struct packed {
        logic armed;
        int   run;
        logic waiting;
        int   since;
        logic holding;
        logic rearming;
        int   low;
        logic pulse;
        logic err;
        int   trips;
    } ch_t;

    function automatic ch_t ch_reset();
        ch_t n;
        n = '0;
        n.armed = 1'b1;
        return n;
    endfunction

    function automatic ch_t step(input ch_t c, input logic s, input logic p);
        ch_t n;
        n = c;
        n.pulse = 1'b0;
        if (c.armed) begin
            n.run = s ? c.run + 1 : 0;
            if (n.run == DEB + 1) begin
                n.pulse   = 1'b1;
                n.armed   = 1'b0;
                n.run     = 0;
                n.waiting = 1'b1;
                n.since   = 0;
                if (c.trips < 255) n.trips = c.trips + 1;
            end
        end else if (c.waiting) begin
            n.since = c.since + 1;
            if (n.since >= 2) begin
                if (p) begin
                    n.waiting = 1'b0;
                    n.holding = 1'b1;
                end else if (n.since == ACK + 1) begin
                    n.waiting  = 1'b0;
                    n.err      = 1'b1;
                    n.rearming = 1'b1;
                    n.low      = 0;
                end
            end
        end else if (c.holding) begin
            if (!p) begin
                n.holding  = 1'b0;
                n.rearming = 1'b1;
                n.low      = 0;
            end
        end else if (c.rearming) begin
            n.low = s ? 0 : c.low + 1;
            if (n.low == RA) begin
                n.rearming = 1'b0;
                n.armed    = 1'b1;
                n.run      = 0;
            end
        end
        return n;
    endfunction

    ch_t        ch_m [2];
    logic [1:0] sy1_m, sy2_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy1_m <= 2'b00;
            sy2_m <= 2'b00;
            for (int i = 0; i < 2; i++) ch_m[i] <= ch_reset();
        end else begin
            sy1_m <= sns_raw;
            sy2_m <= sy1_m;
            for (int i = 0; i < 2; i++) ch_m[i] <= step(ch_m[i], sy2_m[i], pause);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, phase %0d)",
                     name, act, exp, edge_cnt, phase);
        end
    endtask

    // Compare process
    logic [1:0] e_dis, e_busy;
    logic       e_err;
    bit         at_clk;

    always begin
        @(negedge clk or negedge rst_n);
        at_clk = !clk;
        #1;
        e_dis  = {ch_m[1].pulse, ch_m[0].pulse};
        e_busy = {!(ch_m[1].armed && ch_m[1].run == 0), !(ch_m[0].armed && ch_m[0].run == 0)};
        e_err  = ch_m[0].err | ch_m[1].err;
        chk("sns_disable", 32'(sns_disable), 32'(e_dis));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ack_err", 32'(ack_err), 32'(e_err));
`ifdef TRIP_COUNT_EN
        chk("trip_cnt", 32'(trip_cnt), 32'({ch_m[1].trips[7:0], ch_m[0].trips[7:0]}));
`endif
        if (!at_clk && !rst_n) begin
            chk("reset_outputs", 32'({sns_disable, busy, ack_err}), 32'd0);
        end
        if (at_clk) begin
            case (phase)
                1: begin
                    if (edge_cnt == t0 + 3) chk("glitch_qual_busy", 32'(busy), 32'd1);
                    if (edge_cnt == t0 + 8) chk("glitch_rejected", 32'({sns_disable, busy}), 32'd0);
                end
                2: begin
                    if (edge_cnt == t0 + 5) chk("trip_before_pulse", 32'(sns_disable), 32'd0);
                    if (edge_cnt == t0 + 6) chk("trip_pulse", 32'(sns_disable), 32'd1);
                    if (edge_cnt == t0 + 7) chk("trip_after_pulse", 32'(sns_disable), 32'd0);
                    if (edge_cnt == t1 + 4) chk("release_still_busy", 32'(busy), 32'd1);
                    if (edge_cnt == t1 + 5) chk("release_idle", 32'(busy), 32'd0);
                end
                3: begin
                    if (edge_cnt == t0 + 6) chk("simul_pulse", 32'(sns_disable), 32'd3);
                    if (edge_cnt == t1 + 6) chk("press_in_pause", 32'({sns_disable, busy}), 32'd3);
                end
                4: begin
                    if (edge_cnt == t0 + 6)  chk("noack_pulse", 32'(sns_disable), 32'd2);
                    if (edge_cnt == t0 + 10) chk("noack_err_early", 32'(ack_err), 32'd0);
                    if (edge_cnt == t0 + 11) chk("noack_err_set", 32'(ack_err), 32'd1);
                    if (edge_cnt == t0 + 14) chk("noack_rearming", 32'(busy), 32'd2);
                    if (edge_cnt == t0 + 15) chk("noack_rearmed", 32'(busy), 32'd0);
                    if (edge_cnt == t1 + 6)  chk("retrip_pulse_err", 32'({sns_disable, ack_err}), 32'd5);
                end
                5: begin
                    if (edge_cnt == t0 + 10) chk("hold_busy", 32'(busy), 32'd1);
                    if (edge_cnt == t1 + 5)  chk("post_reset_no_pulse", 32'(sns_disable), 32'd0);
                    if (edge_cnt == t1 + 6)  chk("post_reset_pulse", 32'(sns_disable), 32'd1);
                end
                7: begin
                    if (edge_cnt == t0) chk("final_idle", 32'(busy), 32'd0);
`ifdef TRIP_COUNT_EN
                    if (edge_cnt == t0) chk("trip_cnt_saturated", 32'(trip_cnt), 32'h00FF);
`endif
                end
                default: ;
            endcase
        end
    end

    task automatic wait_to(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_phase(input int p, input logic [1:0] raw);
        sns_raw = raw;
        t0      = edge_cnt + 1;
        t1      = BIG;
        phase   = p;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_to(edge_cnt + 2);

        // Glitch of three samples
        start_phase(1, 2'b01);
        wait_to(t0 + 2);
        sns_raw = 2'b00;
        wait_to(t0 + 12);

        // Clean trip with acknowledge
        start_phase(2, 2'b01);
        wait_to(t0 + 8);
        pause = 1'b1;
        wait_to(t0 + 28);
        pause = 1'b0;
        wait_to(t0 + 32);
        sns_raw = 2'b00;
        t1 = edge_cnt + 1;
        wait_to(t1 + 10);

        // Simultaneous trip, second press while paused
        start_phase(3, 2'b11);
        wait_to(t0 + 7);
        pause = 1'b1;
        wait_to(t0 + 9);
        sns_raw = 2'b00;
        wait_to(t0 + 14);
        sns_raw = 2'b11;
        t1 = edge_cnt + 1;
        wait_to(t1 + 10);
        pause   = 1'b0;
        sns_raw = 2'b00;
        wait_to(t1 + 20);

        // No acknowledge on channel 1
        start_phase(4, 2'b10);
        wait_to(t0 + 7);
        sns_raw = 2'b00;
        wait_to(t0 + 17);
        sns_raw = 2'b10;
        t1 = edge_cnt + 1;
        wait_to(t1 + 7);
        sns_raw = 2'b00;
        wait_to(t1 + 20);

        // Reset during HOLD, then a fresh qualification
        start_phase(5, 2'b01);
        wait_to(t0 + 7);
        pause = 1'b1;
        wait_to(t0 + 12);
        rst_n = 1'b0;
        wait_to(t0 + 14);
        pause = 1'b0;
        rst_n = 1'b1;
        t1 = edge_cnt + 1;
        wait_to(t1 + 7);
        sns_raw = 2'b00;
        wait_to(t1 + 20);

        // 300 unacknowledged trips on channel 0
        phase = 6;
        for (int k = 0; k < 300; k++) begin
            sns_raw = 2'b01;
            wait_to(edge_cnt + 7);
            sns_raw = 2'b00;
            wait_to(edge_cnt + 20);
        end

        start_phase(7, 2'b00);
        wait_to(t0 + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
